ibex_taint_mem_responder: RTL and testbench
===========================================

# ibex_taint_mem_responder

Single-port memory responder with shadow taint storage that serves one Ibex memory port (instruction or data) of the CellIFT-instrumented core top. It answers the core's `req`/`gnt`/`rdata` initiator protocol, stores a 32-bit taint word alongside every data word, and returns read data together with its propagated taint. Two instances, one per port, sit beside the instrumented top in simulation and FPGA builds.

## Interface
Parameters:
- `MemDepth`, default `1 << 15`: number of 32-bit words; power of two, at least 2.
- `MemAw`, default `$clog2(MemDepth)`: address width.
- `GntStall`, default 0: cycles `req` is held before `gnt` is given; range 0..15.

Ports (reset is synchronous, active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset.
- `mem_req_i` in 1: request.
- `mem_gnt_o` out 1: grant; the access is performed on the clock edge that ends this cycle.
- `mem_addr_i` in MemAw: word address.
- `mem_wdata_i` in 32: write data.
- `mem_strb_i` in 32: bitwise write strobe.
- `mem_we_i` in 1: write enable.
- `mem_rvalid_o` out 1: response valid, one cycle after a granted access.
- `mem_rdata_o` out 32: read data.
- `mem_req_i_t0`, `mem_we_i_t0` in 1: control taints.
- `mem_addr_i_t0` in MemAw: address taint.
- `mem_wdata_i_t0`, `mem_strb_i_t0` in 32: data and strobe taints.
- `mem_rdata_o_t0` out 32: read-data taint.
- `init_done_o` out 1: taint clear has completed.
- `tainted_write_o` out 1: sticky flag, set by any granted write with tainted control.

## Operation
FSM states are CLEAR, READY, STALL.
- **CLEAR** (entered on reset):
  - `clr_cnt` runs 0..MemDepth-1 and writes 0 to `taint_mem[clr_cnt]`, one word per cycle.
  - `mem_gnt_o` = 0 throughout.
  - After the last word, go to READY and set `init_done_o` = 1.
  - Data memory is not cleared; its contents are undefined until written.
- **READY**:
  - If `GntStall` == 0: `mem_gnt_o` = `mem_req_i`, combinationally.
  - Otherwise, `mem_req_i` = 1 moves the FSM to STALL with `stall_cnt` = 1; no grant this cycle.
- **STALL**:
  - `mem_gnt_o` = `mem_req_i && stall_cnt == GntStall`.
  - `stall_cnt` increments each cycle while `mem_req_i` is high and not granted.
  - On grant, or if `mem_req_i` drops, return to READY with `stall_cnt` = 0.
- **Control taint**: `ctl_t` = `mem_req_i_t0 | mem_we_i_t0 | (|mem_addr_i_t0)`.
- **Granted write**, for each bit i:
  - `data_mem[a][i]` = `strb[i] ? wdata[i] : old`.
  - `taint_mem[a][i]` = `strb[i] ? (wdata_t0[i] | strb_t0[i] | ctl_t) : (old_t[i] | strb_t0[i])`.
  - If `ctl_t` = 1, set `tainted_write_o`.
- **Granted read**: next cycle, `mem_rdata_o` = `data_mem[a]` and `mem_rdata_o_t0` = `taint_mem[a] | {32{ctl_t}}`. Taint is registered with the request.
- **Write response**: `mem_rvalid_o` pulses; `mem_rdata_o` and `mem_rdata_o_t0` = 0.
- `mem_rdata_o` and `mem_rdata_o_t0` hold their value while `mem_rvalid_o` = 0.
- Address wrap-around cannot occur, since MemAw = clog2(MemDepth).

## Timing
- **Reset values**: `mem_gnt_o` = 0, `mem_rvalid_o` = 0, `mem_rdata_o` = 0, `mem_rdata_o_t0` = 0, `init_done_o` = 0, `tainted_write_o` = 0. State = CLEAR, `clr_cnt` = 0, `stall_cnt` = 0.
- **Clear duration**: exactly MemDepth cycles after `rst_ni` rises.
- **Reset mid-CLEAR or mid-STALL**: restarts CLEAR from 0. Outputs take reset values on the next edge.
- **Grant latency**: request to grant is `GntStall` cycles. Grant to `mem_rvalid_o` is 1 cycle.
- **Throughput**: with `GntStall` = 0, back-to-back grants give one access per cycle.
- **Read-after-write, same address, consecutive grants**: the read returns the newly written data and taint.
- **`mem_req_i` dropped before grant**: no access, no response, `stall_cnt` cleared.
- **`mem_gnt_o` depends combinationally on `mem_req_i`**: no other input-to-output combinational path exists.

## Test plan
- **Reset/clear**: MemDepth = 16, hold `req` from reset. Expect `gnt` = 0 for 16 cycles, then `init_done_o` = 1 and `gnt` on cycle 17. A read of addr 3 returns `rdata_t0` = 0.
- **Strobed write and read**:
  - Write addr 5, `wdata` = 0xDEADBEEF, `strb` = 0x0000FFFF, `wdata_t0` = 0x000000F0.
  - Then write addr 5, `wdata` = 0x12345678, `strb` = 0xFFFF0000, `wdata_t0` = 0.
  - Read addr 5 → `rdata` = 0x1234BEEF, `rdata_t0` = 0x000000F0, one cycle after `gnt`.
- **Tainted address**:
  - Read with `addr_t0` = 1 → `rdata_t0` = 0xFFFFFFFF.
  - Write with `we_t0` = 1, `strb` = 0x000000FF → `tainted_write_o` = 1 and stays 1. A later clean read of that word gives `rdata_t0` = 0x000000FF.
- **Stall**: `GntStall` = 3, `req` held → `gnt` in the 4th request cycle, `rvalid` in the 5th. With `req` dropped after 2 cycles → no `gnt`, no `rvalid`, and a fresh request again waits 3 cycles.
- **Back-to-back**: `GntStall` = 0, write addr 7 = 0xA5A5A5A5, then read addr 7 on the next cycle → `rvalid` on consecutive cycles, and the read returns 0xA5A5A5A5.
- **Reset mid-clear**: assert `rst_ni` = 0 at `clr_cnt` = 9 (MemDepth = 16) → `init_done_o` = 1 only 16 cycles after reset release.

Source files
------------

// File: rtl/ibex_taint_mem_responder.sv
// Single-port memory responder with shadow taint storage for one Ibex memory
// port. Answers the req/gnt/rvalid initiator protocol, keeps a 32-bit taint
// word beside every data word and returns read data with its propagated taint.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing taint_mem one word per cycle, no grants
// ST_READY | idle; grants immediately when GntStall == 0
// ST_STALL | request pending, counting up to GntStall before granting

module ibex_taint_mem_responder #(
    parameter int unsigned MemDepth = 1 << 15,
    parameter int unsigned MemAw    = $clog2(MemDepth),
    parameter int unsigned GntStall = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              mem_req_i,
    output logic              mem_gnt_o,
    input  logic [MemAw-1:0]  mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [31:0]       mem_strb_i,
    input  logic              mem_we_i,
    output logic              mem_rvalid_o,
    output logic [31:0]       mem_rdata_o,

    input  logic              mem_req_i_t0,
    input  logic              mem_we_i_t0,
    input  logic [MemAw-1:0]  mem_addr_i_t0,
    input  logic [31:0]       mem_wdata_i_t0,
    input  logic [31:0]       mem_strb_i_t0,
    output logic [31:0]       mem_rdata_o_t0,

    output logic              init_done_o,
    output logic              tainted_write_o
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_READY,
        ST_STALL
    } state_e;

    localparam logic [MemAw-1:0] ClrLast = MemAw'(MemDepth - 1);
    localparam logic [3:0]       StallTc = 4'(GntStall);

    state_e            state_q, state_d;
    logic [MemAw-1:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]        stall_cnt_q, stall_cnt_d;
    logic              init_done_q;
    logic              gnt;
    logic              clr_we;

    logic [31:0]       data_mem  [MemDepth];
    logic [31:0]       taint_mem [MemDepth];

    logic              ctl_t;
    logic              wr_en;
    logic [31:0]       data_old;
    logic [31:0]       taint_old;
    logic [31:0]       data_new;
    logic [31:0]       taint_new;

    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_t0_q;
    logic              tainted_write_q;

    // Next-state, grant and clear-write decode
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        gnt         = 1'b0;
        clr_we      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt_q == ClrLast) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + MemAw'(1);
                end
            end

            ST_READY: begin
                if (GntStall == 0) begin
                    gnt = mem_req_i;
                end else if (mem_req_i) begin
                    state_d     = ST_STALL;
                    stall_cnt_d = 4'd1;
                end
            end

            ST_STALL: begin
                gnt = mem_req_i && (stall_cnt_q == StallTc);
                if (!mem_req_i || gnt) begin
                    state_d     = ST_READY;
                    stall_cnt_d = 4'd0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d     = ST_CLEAR;
                clr_cnt_d   = '0;
                stall_cnt_d = 4'd0;
            end
        endcase
    end

    // FSM state, counters and the init-done flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            stall_cnt_q <= 4'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            init_done_q <= (state_d != ST_CLEAR);
        end
    end

    // Merge strobed write data and propagate taint; any tainted control bit
    // taints every strobed bit, while strobe taint reaches every bit.
    always_comb begin
        ctl_t     = mem_req_i_t0 | mem_we_i_t0 | (|mem_addr_i_t0);
        wr_en     = gnt & mem_we_i;
        data_old  = data_mem[mem_addr_i];
        taint_old = taint_mem[mem_addr_i];
        data_new  = (data_old & ~mem_strb_i) | (mem_wdata_i & mem_strb_i);
        taint_new = (mem_strb_i & (mem_wdata_i_t0 | mem_strb_i_t0 | {32{ctl_t}}))
                  | (~mem_strb_i & (taint_old | mem_strb_i_t0));
    end

    // Data array: written only by granted writes, never cleared
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            data_mem[mem_addr_i] <= data_new;
        end
    end

    // Taint array: zeroed during CLEAR, otherwise written by granted writes
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            taint_mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            taint_mem[mem_addr_i] <= taint_new;
        end
    end

    // Response register: one-cycle latency, holds value between responses
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rdata_t0_q <= '0;
        end else if (gnt) begin
            rvalid_q <= 1'b1;
            if (mem_we_i) begin
                rdata_q    <= '0;
                rdata_t0_q <= '0;
            end else begin
                rdata_q    <= data_mem[mem_addr_i];
                rdata_t0_q <= taint_mem[mem_addr_i] | {32{ctl_t}};
            end
        end else begin
            rvalid_q <= 1'b0;
        end
    end

    // Sticky flag for granted writes carrying tainted control
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tainted_write_q <= 1'b0;
        end else if (wr_en && ctl_t) begin
            tainted_write_q <= 1'b1;
        end
    end

    assign mem_gnt_o       = gnt;
    assign mem_rvalid_o    = rvalid_q;
    assign mem_rdata_o     = rdata_q;
    assign mem_rdata_o_t0  = rdata_t0_q;
    assign init_done_o     = init_done_q;
    assign tainted_write_o = tainted_write_q;

endmodule

// File: tb/tb_ibex_taint_mem_responder.sv
// Bench for ibex_taint_mem_responder: instance A (no grant stall) and
// instance B (three-cycle grant stall), both with a 16-word memory.

module tb_ibex_taint_mem_responder;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] t0;
    } exp_s;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_s qa[$];
    exp_s qb[$];
    exp_s ea, eb;

    logic        a_rst_n, a_req, a_gnt, a_we, a_rvalid, a_req_t0, a_we_t0, a_init, a_tw;
    logic [3:0]  a_addr, a_addr_t0;
    logic [31:0] a_wdata, a_strb, a_rdata, a_wdata_t0, a_strb_t0, a_rdata_t0;

    logic        b_rst_n, b_req, b_gnt, b_we, b_rvalid, b_req_t0, b_we_t0, b_init, b_tw;
    logic [3:0]  b_addr, b_addr_t0;
    logic [31:0] b_wdata, b_strb, b_rdata, b_wdata_t0, b_strb_t0, b_rdata_t0;

    ibex_taint_mem_responder #(.MemDepth(16), .GntStall(0)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n),
        .mem_req_i(a_req), .mem_gnt_o(a_gnt), .mem_addr_i(a_addr),
        .mem_wdata_i(a_wdata), .mem_strb_i(a_strb), .mem_we_i(a_we),
        .mem_rvalid_o(a_rvalid), .mem_rdata_o(a_rdata),
        .mem_req_i_t0(a_req_t0), .mem_we_i_t0(a_we_t0), .mem_addr_i_t0(a_addr_t0),
        .mem_wdata_i_t0(a_wdata_t0), .mem_strb_i_t0(a_strb_t0), .mem_rdata_o_t0(a_rdata_t0),
        .init_done_o(a_init), .tainted_write_o(a_tw)
    );

    ibex_taint_mem_responder #(.MemDepth(16), .GntStall(3)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n),
        .mem_req_i(b_req), .mem_gnt_o(b_gnt), .mem_addr_i(b_addr),
        .mem_wdata_i(b_wdata), .mem_strb_i(b_strb), .mem_we_i(b_we),
        .mem_rvalid_o(b_rvalid), .mem_rdata_o(b_rdata),
        .mem_req_i_t0(b_req_t0), .mem_we_i_t0(b_we_t0), .mem_addr_i_t0(b_addr_t0),
        .mem_wdata_i_t0(b_wdata_t0), .mem_strb_i_t0(b_strb_t0), .mem_rdata_o_t0(b_rdata_t0),
        .init_done_o(b_init), .tainted_write_o(b_tw)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop one expectation per response
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_rdata", a_rdata & ea.mask, ea.data & ea.mask);
                chk("a_rdata_t0", a_rdata_t0, ea.t0);
            end
        end
    end

    always @(negedge clk) begin
        if (b_rvalid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_rdata", b_rdata & eb.mask, eb.data & eb.mask);
                chk("b_rdata_t0", b_rdata_t0, eb.t0);
            end
        end
    end

    // One access on A; granted in the same cycle. Entered and left at posedge+1.
    task automatic a_acc(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                         input logic [31:0] strb, input logic [31:0] wdt,
                         input logic rqt, input logic wet, input logic [3:0] adt,
                         input logic [31:0] mask, input logic [31:0] ed, input logic [31:0] et);
        exp_s e;
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_strb = strb;
        a_wdata_t0 = wdt; a_strb_t0 = '0; a_req_t0 = rqt; a_we_t0 = wet; a_addr_t0 = adt;
        @(negedge clk);
        chk("a_gnt", 32'(a_gnt), 32'd1);
        if (a_gnt) begin
            e.mask = mask; e.data = ed; e.t0 = et;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        a_req = 1'b0; a_we = 1'b0; a_req_t0 = 1'b0; a_we_t0 = 1'b0;
        a_addr_t0 = '0; a_wdata_t0 = '0;
    endtask

    // Count clear cycles on A right after reset release
    task automatic a_clear_check(input bit with_req);
        exp_s e;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk("a_clr_gnt", 32'(a_gnt), 32'd0);
            chk("a_clr_init", 32'(a_init), 32'd0);
        end
        @(negedge clk);
        chk("a_init_after_clear", 32'(a_init), 32'd1);
        if (with_req) begin
            chk("a_gnt_after_clear", 32'(a_gnt), 32'd1);
            if (a_gnt) begin
                e.mask = '0; e.data = '0; e.t0 = '0;
                qa.push_back(e);
            end
        end
        @(posedge clk); #1;
        a_req = 1'b0;
    endtask

    // One access on B with the request held until grant (3 cycles of stall)
    task automatic b_stall_acc(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                               input logic [31:0] mask, input logic [31:0] ed,
                               input logic [31:0] et);
        exp_s e;
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_strb = 32'hFFFF_FFFF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("b_stall_gnt", 32'(b_gnt), 32'd0);
            chk("b_stall_rvalid", 32'(b_rvalid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b_gnt_4th", 32'(b_gnt), 32'd1);
        if (b_gnt) begin
            e.mask = mask; e.data = ed; e.t0 = et;
            qb.push_back(e);
        end
        @(posedge clk); #1;
        b_req = 1'b0; b_we = 1'b0;
        @(negedge clk);
        chk("b_rvalid_5th", 32'(b_rvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_strb = '0;
        a_req_t0 = 1'b0; a_we_t0 = 1'b0; a_addr_t0 = '0; a_wdata_t0 = '0; a_strb_t0 = '0;
        b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_strb = '0;
        b_req_t0 = 1'b0; b_we_t0 = 1'b0; b_addr_t0 = '0; b_wdata_t0 = '0; b_strb_t0 = '0;

        repeat (2) @(posedge clk);
        #1;
        a_req = 1'b1; a_addr = 4'd3;
        @(negedge clk);
        chk("rst_gnt", 32'(a_gnt), 32'd0);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_rdata_t0", a_rdata_t0, 32'd0);
        chk("rst_init", 32'(a_init), 32'd0);
        chk("rst_tw", 32'(a_tw), 32'd0);
        chk("b_rst_init", 32'(b_init), 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Clear with request held: read of addr 3 returns clean taint
        a_clear_check(1'b1);
        chk("b_init_done", 32'(b_init), 32'd1);

        // Strobed writes and read-back
        a_acc(1'b1, 4'd5, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_00F0, 1'b0, 1'b0, 4'd0,
              32'hFFFF_FFFF, 32'h0, 32'h0);
        a_acc(1'b1, 4'd5, 32'h1234_5678, 32'hFFFF_0000, 32'h0, 1'b0, 1'b0, 4'd0,
              32'hFFFF_FFFF, 32'h0, 32'h0);
        a_acc(1'b0, 4'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'hFFFF_FFFF, 32'h1234_BEEF, 32'h0000_00F0);
        @(posedge clk); #1;
        chk("tw_before", 32'(a_tw), 32'd0);

        // Tainted-control write, then clean read of that word
        a_acc(1'b1, 4'd9, 32'h1122_3344, 32'h0000_00FF, 32'h0, 1'b0, 1'b1, 4'd0,
              32'hFFFF_FFFF, 32'h0, 32'h0);
        a_acc(1'b0, 4'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'h0000_00FF, 32'h0000_0044, 32'h0000_00FF);
        chk("tw_set", 32'(a_tw), 32'd1);

        // Back-to-back write/read of addr 7, then tainted-address read of addr 5
        a_acc(1'b1, 4'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 4'd0,
              32'hFFFF_FFFF, 32'h0, 32'h0);
        a_acc(1'b0, 4'd7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h0);
        a_acc(1'b0, 4'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1,
              32'hFFFF_FFFF, 32'h1234_BEEF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        chk("hold_rvalid", 32'(a_rvalid), 32'd0);
        chk("hold_rdata", a_rdata, 32'h1234_BEEF);
        chk("hold_rdata_t0", a_rdata_t0, 32'hFFFF_FFFF);
        chk("tw_sticky", 32'(a_tw), 32'd1);
        @(posedge clk); #1;

        // Stall behaviour on B
        b_stall_acc(1'b1, 4'd2, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0, 32'h0);
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("b_drop_gnt", 32'(b_gnt), 32'd0);
            @(posedge clk); #1;
        end
        b_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("b_drop_idle_gnt", 32'(b_gnt), 32'd0);
            chk("b_drop_rvalid", 32'(b_rvalid), 32'd0);
            @(posedge clk); #1;
        end
        b_stall_acc(1'b0, 4'd2, 32'h0, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0);
        chk("b_tw_clean", 32'(b_tw), 32'd0);

        // Reset A, then reset again mid-clear at clr_cnt = 9
        a_rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("rerst_init", 32'(a_init), 32'd0);
        chk("rerst_tw", 32'(a_tw), 32'd0);
        a_rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        a_clear_check(1'b0);

        // Taint cleared, data untouched
        a_acc(1'b0, 4'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'hFFFF_FFFF, 32'h1234_BEEF, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
